// File: rtl/kred_mul_pipe_pkg.sv
// Shared arithmetic definitions for the Kyber/Dilithium multiply and adder stages:
// moduli, latency, mode encoding, sideband payload and the Barrett constant helper.
package kred_mul_pipe_pkg;

    localparam int unsigned DATA_W  = 24;
    localparam int unsigned TAG_W   = 3;
    localparam int unsigned KY_W    = 12;
    localparam int unsigned DL_W    = 23;
    localparam int unsigned KYBER_Q = 3329;
    localparam int unsigned DIL_Q   = 8380417;
    localparam int unsigned MUL_LAT = 6;

    typedef enum logic {
        MODE_KYBER = 1'b0,
        MODE_DIL   = 1'b1
    } mode_e;

    typedef struct packed {
        logic              valid;
        mode_e             mode;
        logic [TAG_W-1:0]  tag;
    } side_t;

    // floor(2^k / m): the Barrett multiplier for a reduction shift of k bits
    function automatic longint unsigned barrett_const(input int unsigned k, input int unsigned m);
        return (64'd1 << k) / 64'(m);
    endfunction

endpackage

// File: rtl/kred_barrett_red.sv
// Three-stage Barrett reduction of a product x < MOD^2 (2*MW bits) to [0, MOD-1].
// Shift is 2*MW, so the quotient estimate is short by at most 2 and two subtractions suffice.
module kred_barrett_red
    import kred_mul_pipe_pkg::*;
#(
    parameter int unsigned MOD = KYBER_Q,
    parameter int unsigned MW  = KY_W
) (
    input  logic            clk,
    input  logic [2*MW-1:0] x,
    output logic [MW-1:0]   r
);

    localparam int unsigned XW = 2 * MW;
    localparam int unsigned CW = MW + 1;
    localparam int unsigned PW = XW + CW;
    localparam int unsigned RW = MW + 2;

    localparam logic [CW-1:0] BC   = CW'(barrett_const(XW, MOD));
    localparam logic [RW-1:0] MODR = RW'(MOD);

    logic [XW-1:0] x1;
    logic [CW-1:0] q1;
    logic [RW-1:0] r2;
    logic [RW-1:0] s1_c;
    logic [RW-1:0] s2_c;

    // Stage 1: quotient estimate
    always_ff @(posedge clk) begin
        x1 <= x;
        q1 <= CW'((PW'(x) * PW'(BC)) >> XW);
    end

    // Stage 2: remainder in [0, 3*MOD), computed modulo 2^XW then narrowed
    always_ff @(posedge clk) begin
        r2 <= RW'(x1 - XW'(q1) * XW'(MOD));
    end

    always_comb begin
        s1_c = (r2 >= MODR) ? (r2 - MODR) : r2;
        s2_c = (s1_c >= MODR) ? (s1_c - MODR) : s1_c;
    end

    // Stage 3: canonical result
    always_ff @(posedge clk) begin
        r <= MW'(s2_c);
    end

endmodule

// File: rtl/kred_mul_pipe.sv
// Dual-mode modular multiplier: two 12-bit Kyber lanes or one 23-bit Dilithium lane,
// fully pipelined with a fixed 6-cycle latency and per-sample mode/tag sideband.
module kred_mul_pipe
    import kred_mul_pipe_pkg::*;
#(
    parameter int unsigned LAT = MUL_LAT,
    parameter int unsigned KQ  = KYBER_Q,
    parameter int unsigned DQ  = DIL_Q
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              mode,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic [DATA_W-1:0] mul_a,
    input  logic [DATA_W-1:0] mul_w,
    output logic              out_valid,
    output logic [TAG_W-1:0]  tag_out,
    output logic              mode_out,
    output logic [DATA_W-1:0] mul_p
);

    localparam int unsigned KPW = 2 * KY_W;
    localparam int unsigned DPW = 2 * DL_W;

    side_t side_c;
    side_t side_sr [LAT];

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] w_q;
    logic [KPW-1:0]    prod_h;
    logic [KPW-1:0]    prod_l;
    logic [DPW-1:0]    prod_d;
    logic [KY_W-1:0]   red_h;
    logic [KY_W-1:0]   red_l;
    logic [DL_W-1:0]   red_d;

    always_comb begin
        side_c       = '0;
        side_c.valid = in_valid;
        side_c.mode  = mode_e'(mode);
        side_c.tag   = tag_in;
    end

    // Valid/mode/tag delay line; stage i lines up with datapath stage i+1
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) side_sr[i] <= '0;
        end else begin
            side_sr[0] <= side_c;
            for (int i = 1; i < LAT; i++) side_sr[i] <= side_sr[i-1];
        end
    end

    // Operand capture and products; both modes are computed every cycle
    always_ff @(posedge clk) begin
        a_q    <= mul_a;
        w_q    <= mul_w;
        prod_h <= KPW'(a_q[DATA_W-1:KY_W]) * KPW'(w_q[DATA_W-1:KY_W]);
        prod_l <= KPW'(a_q[KY_W-1:0]) * KPW'(w_q[KY_W-1:0]);
        prod_d <= DPW'(a_q[DL_W-1:0]) * DPW'(w_q[DL_W-1:0]);
    end

    kred_barrett_red #(.MOD(KQ), .MW(KY_W)) u_red_hi (
        .clk (clk),
        .x   (prod_h),
        .r   (red_h)
    );

    kred_barrett_red #(.MOD(KQ), .MW(KY_W)) u_red_lo (
        .clk (clk),
        .x   (prod_l),
        .r   (red_l)
    );

    kred_barrett_red #(.MOD(DQ), .MW(DL_W)) u_red_dil (
        .clk (clk),
        .x   (prod_d),
        .r   (red_d)
    );

    // Output select; bubbles load zero so mul_p is never unknown after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_p <= '0;
        end else if (!side_sr[LAT-2].valid) begin
            mul_p <= '0;
        end else if (side_sr[LAT-2].mode == MODE_DIL) begin
            mul_p <= {1'b0, red_d};
        end else begin
            mul_p <= {red_h, red_l};
        end
    end

    assign out_valid = side_sr[LAT-1].valid;
    assign tag_out   = side_sr[LAT-1].tag;
    assign mode_out  = side_sr[LAT-1].mode;

endmodule

// File: tb/tb_kred_mul_pipe.sv
// Directed and random checks of kred_mul_pipe against hand-computed values and a % model.
module tb_kred_mul_pipe;

    localparam int unsigned LAT = 6;
    localparam int unsigned KQ  = 3329;
    localparam int unsigned DQ  = 8380417;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        mode;
    logic [2:0]  tag_in;
    logic [23:0] mul_a;
    logic [23:0] mul_w;
    logic        out_valid;
    logic [2:0]  tag_out;
    logic        mode_out;
    logic [23:0] mul_p;

    typedef struct {
        logic        v;
        logic        md;
        logic [2:0]  tg;
        logic [23:0] p;
    } want_t;

    want_t want_q [LAT];
    int    n_chk;
    int    n_pass;

    logic [23:0] ra;
    logic [23:0] rw;
    logic        rmd;

    kred_mul_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .mode      (mode),
        .tag_in    (tag_in),
        .mul_a     (mul_a),
        .mul_w     (mul_w),
        .out_valid (out_valid),
        .tag_out   (tag_out),
        .mode_out  (mode_out),
        .mul_p     (mul_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] want);
        n_chk++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    endtask

    // Reference product by plain modulo arithmetic
    function automatic logic [23:0] model(input logic md, input logic [23:0] a, input logic [23:0] w);
        longint unsigned pa;
        longint unsigned pw;
        logic [11:0]     hi;
        if (md) begin
            pa = 64'(a[22:0]);
            pw = 64'(w[22:0]);
            return {1'b0, 23'((pa * pw) % 64'(DQ))};
        end
        pa = 64'(a[23:12]);
        pw = 64'(w[23:12]);
        hi = 12'((pa * pw) % 64'(KQ));
        pa = 64'(a[11:0]);
        pw = 64'(w[11:0]);
        return {hi, 12'((pa * pw) % 64'(KQ))};
    endfunction

    function automatic logic [23:0] rand_op(input logic md);
        if (md) return 24'($urandom_range(0, DQ - 1));
        return {12'($urandom_range(0, KQ - 1)), 12'($urandom_range(0, KQ - 1))};
    endfunction

    // Called at a falling edge: check the slot driven LAT cycles ago, drive a new one
    task automatic step(input logic v, input logic md, input logic [2:0] tg,
                        input logic [23:0] a, input logic [23:0] w, input logic [23:0] p);
        chk("out_valid", 24'(out_valid), 24'(want_q[LAT-1].v));
        chk("tag_out", 24'(tag_out), 24'(want_q[LAT-1].tg));
        chk("mode_out", 24'(mode_out), 24'(want_q[LAT-1].md));
        if (want_q[LAT-1].v) chk("mul_p", mul_p, want_q[LAT-1].p);
        in_valid = v;
        mode     = md;
        tag_in   = tg;
        mul_a    = a;
        mul_w    = w;
        for (int i = LAT - 1; i > 0; i--) want_q[i] = want_q[i-1];
        want_q[0] = '{v, md, tg, p};
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 24'd0, 24'd0, 24'd0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        mode     = 1'b0;
        tag_in   = 3'd0;
        mul_a    = 24'd0;
        mul_w    = 24'd0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < LAT; i++) want_q[i] = '{1'b0, 1'b0, 3'd0, 24'd0};
        chk("rst_out_valid", 24'(out_valid), 24'd0);
        chk("rst_tag_out", 24'(tag_out), 24'd0);
        chk("rst_mode_out", 24'(mode_out), 24'd0);
        chk("rst_mul_p", mul_p, 24'd0);
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        mode     = 1'b0;
        tag_in   = 3'd0;
        mul_a    = 24'd0;
        mul_w    = 24'd0;
        @(negedge clk);
        do_reset();

        // Kyber single sample: 3328^2 = 1, 17^2 = 289
        step(1'b1, 1'b0, 3'd5, {12'd3328, 12'd17}, {12'd3328, 12'd17}, {12'd1, 12'd289});
        idle(LAT);

        // Dilithium directed and boundary values, Kyber edge lanes
        step(1'b1, 1'b1, 3'd2, 24'd8380416, 24'd8380416, 24'd1);
        step(1'b1, 1'b1, 3'd7, 24'd4096, 24'd4096, 24'd16382);
        step(1'b1, 1'b1, 3'd1, 24'd8380416, 24'd2, 24'd8380415);
        step(1'b1, 1'b1, 3'd4, 24'd1, 24'd8380416, 24'd8380416);
        step(1'b1, 1'b0, 3'd6, {12'd1, 12'd3328}, {12'd3328, 12'd1}, {12'd3328, 12'd3328});
        step(1'b1, 1'b0, 3'd3, {12'd0, 12'd5}, {12'd7, 12'd0}, 24'd0);
        step(1'b1, 1'b1, 3'd0, 24'd0, 24'd8380416, 24'd0);
        step(1'b1, 1'b0, 3'd5, {12'd3328, 12'd3328}, {12'd3328, 12'd3328}, {12'd1, 12'd1});

        // Valid pattern 1,0,0,1,1,0 with a={3328,2}, w={2,3328}
        step(1'b1, 1'b0, 3'd1, {12'd3328, 12'd2}, {12'd2, 12'd3328}, {12'd3327, 12'd3327});
        step(1'b0, 1'b0, 3'd2, {12'd3328, 12'd2}, {12'd2, 12'd3328}, 24'd0);
        step(1'b0, 1'b0, 3'd3, {12'd3328, 12'd2}, {12'd2, 12'd3328}, 24'd0);
        step(1'b1, 1'b0, 3'd4, {12'd3328, 12'd2}, {12'd2, 12'd3328}, {12'd3327, 12'd3327});
        step(1'b1, 1'b0, 3'd5, {12'd3328, 12'd2}, {12'd2, 12'd3328}, {12'd3327, 12'd3327});
        step(1'b0, 1'b0, 3'd6, {12'd3328, 12'd2}, {12'd2, 12'd3328}, 24'd0);

        // Alternating modes every cycle, tags cycling 0..7
        for (int i = 0; i < 20; i++) begin
            rmd = 1'(i % 2);
            ra  = rand_op(rmd);
            rw  = rand_op(rmd);
            step(1'b1, rmd, 3'(i % 8), ra, rw, model(rmd, ra, rw));
        end
        idle(LAT);

        // Four in flight, then reset discards them
        step(1'b1, 1'b0, 3'd1, {12'd3328, 12'd17}, {12'd3328, 12'd17}, {12'd1, 12'd289});
        step(1'b1, 1'b1, 3'd2, 24'd4096, 24'd4096, 24'd16382);
        step(1'b1, 1'b0, 3'd3, {12'd3328, 12'd2}, {12'd2, 12'd3328}, {12'd3327, 12'd3327});
        step(1'b1, 1'b1, 3'd4, 24'd8380416, 24'd8380416, 24'd1);
        do_reset();
        step(1'b1, 1'b1, 3'd6, 24'd4096, 24'd4096, 24'd16382);
        idle(LAT);

        // Random legal samples in both modes with random valid gaps
        for (int i = 0; i < 10000; i++) begin
            rmd = 1'($urandom_range(0, 1));
            ra  = rand_op(rmd);
            rw  = rand_op(rmd);
            step(($urandom_range(0, 7) != 0), rmd, 3'($urandom_range(0, 7)), ra, rw, model(rmd, ra, rw));
        end
        idle(LAT);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
